tmr_array_scrubber: RTL and testbench
=====================================

Name: tmr_array_scrubber

Overview:
- Triple-redundant storage array with a majority-voted read port and a background scrub sequencer.
- The scrubber walks every entry, votes the three copies and writes the corrected word back to all three.
- The array index range is parameterised and may be ascending or descending.
- Serves as the writer/corrector counterpart to the voting read paths the TMR flow inserts, and as a regression block for range-direction handling.

Parameters:
- WIDTH, 8, data bits per entry.
- AFROM, 0, first index of the array range as declared.
- ATO, 7, last index of the array range; AFROM > ATO declares a descending range.
- ADDR_W, 3, address port width; must cover both AFROM and ATO.
- CNT_W, 8, width of the saturating correction counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  user write strobe
- wr_addr  in  ADDR_W  user write index
- wr_data  in  WIDTH  user write data
- rd_en  in  1  user read strobe
- rd_addr  in  ADDR_W  user read index
- rd_data  out  WIDTH  voted read data
- rd_valid  out  1  rd_data valid
- rd_err  out  1  copies disagreed on this read
- inj_en  in  1  fault-injection strobe
- inj_copy  in  2  copy to corrupt: 0, 1 or 2; 3 is ignored
- inj_addr  in  ADDR_W  fault-injection index
- inj_mask  in  WIDTH  bits to XOR into the selected copy
- scrub_start  in  1  start one scrub pass
- scrub_busy  out  1  pass in progress
- scrub_done  out  1  one-cycle pulse at end of pass
- corr_cnt  out  CNT_W  saturating count of corrected entries

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - outputs: rd_data=0, rd_valid=0, rd_err=0, scrub_busy=0, scrub_done=0, corr_cnt=0.
  - FSM returns to IDLE.
  - Array contents are not cleared.
  - Reset mid-pass aborts the pass with no scrub_done pulse.
- Index validity: an index is valid when it lies between min(AFROM,ATO) and max(AFROM,ATO) inclusive. Operations on invalid indices are ignored: no write, and a read returns rd_valid=1, rd_data=0, rd_err=0.
- Write: wr_en writes wr_data to all three copies at the clk edge.
- Read: registered, latency 1.
  - rd_valid = rd_en delayed one cycle.
  - rd_data = bitwise majority of the three copies.
  - rd_err = 1 if any bit differs among the copies.
  - Read-during-write to the same index returns the old contents.
- Injection: inj_en XORs inj_mask into copy inj_copy only. Injection has the lowest priority; it is dropped if a user or scrub write targets the same index in the same cycle.
- Scrub FSM, one entry every 2 cycles:
  - IDLE: scrub_start -> LOAD with ptr=AFROM and scrub_busy=1. scrub_start is ignored while busy.
  - LOAD: latch the three copies at ptr -> CHECK.
  - CHECK:
    - If the copies disagree, write the voted word to all three copies and increment corr_cnt, saturating at 2^CNT_W-1.
    - If ptr==ATO -> DONE.
    - Otherwise step ptr toward ATO (+1 if AFROM<=ATO, else -1) -> LOAD.
  - DONE: scrub_done=1 for one cycle, scrub_busy=0 -> IDLE.
  - A pass over N entries takes 2N+1 cycles from the cycle after scrub_start to scrub_done.
- Collision: if user wr_en hits the same index as a CHECK write-back in the same cycle, the user write wins. The scrub write-back and its count increment are suppressed, and the entry is not retried.
- Single-entry range (AFROM==ATO): one LOAD/CHECK, then DONE.
- Voting uses only copies held in this block. Outputs are single-copy; external triplication is applied by the flow.

Decomposition:
- Package tmr_scrub_pkg:
  - FSM state enum (IDLE, LOAD, CHECK, DONE).
  - Constant for copy count 3.
  - Helper function for the majority vote.
  - Helper function for the index-valid test.
- One natural sub-module, tmr_majority_voter:
  - Combinational WIDTH-bit 3-input majority with disagreement flag.
  - Instantiated once for the read port and once for the scrubber.

Test Plan:
1. AFROM=0, ATO=7: write 0xA5 to index 3; read 3 -> next cycle rd_valid=1, rd_data=0xA5, rd_err=0.
2. Inject copy=1, addr=3, mask=0x0F; read 3 -> rd_data=0xA5, rd_err=1. Then scrub_start -> scrub_done 17 cycles later, corr_cnt=1; read 3 -> rd_err=0.
3. AFROM=7, ATO=0: corrupt indices 7 and 0 in different copies; scrub -> ptr visits 7,6,...,0, corr_cnt=2, scrub_done after 17 cycles.
4. Collision: inject at 5, start scrub, assert wr_en to 5 with 0x3C in the cycle the scrubber's CHECK targets 5 -> memory holds 0x3C, corr_cnt unchanged.
5. Reset mid-pass: rst in a LOAD cycle -> scrub_busy=0 and corr_cnt=0 next cycle, no scrub_done. An injected entry not yet reached still reads rd_err=1.
6. Saturation and edge ranges:
   - CNT_W=2: four corrupted entries, one pass -> corr_cnt=3.
   - AFROM=ATO=7: pass completes in 3 cycles.
   - Read of index 9 -> rd_data=0, rd_err=0.

Source files
------------

// File: rtl/tmr_scrub_pkg.sv
// Shared types and helpers for the triple-redundant array and its scrubber.
// Holds the scrub FSM encoding, the copy count, the bitwise vote and the index range test.
package tmr_scrub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } scrub_state_t;

    localparam int COPIES = 3;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // The range may be declared in either direction; validity only depends on its bounds.
    function automatic logic idx_valid(input int idx, input int afrom, input int ato);
        int lo;
        int hi;
        lo = (afrom < ato) ? afrom : ato;
        hi = (afrom < ato) ? ato : afrom;
        return (idx >= lo) && (idx <= hi);
    endfunction

endpackage

// File: rtl/tmr_majority_voter.sv
// Combinational WIDTH-bit three-way majority vote.
// mismatch flags any bit on which the three copies are not unanimous.
module tmr_majority_voter
    import tmr_scrub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] voted,
    output logic             mismatch
);

    always_comb begin
        voted = '0;
        for (int i = 0; i < WIDTH; i++) begin
            voted[i] = maj3(a[i], b[i], c[i]);
        end
    end

    assign mismatch = |((a ^ b) | (a ^ c));

endmodule

// File: rtl/tmr_array_scrubber.sv
// Triple-redundant array with a voted, 1-cycle registered read port and a background scrubber.
// The scrubber visits one entry every two cycles, walking from AFROM toward ATO, and rewrites disagreeing entries.
module tmr_array_scrubber
    import tmr_scrub_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int AFROM  = 0,
    parameter int ATO    = 7,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    input  logic              inj_en,
    input  logic [1:0]        inj_copy,
    input  logic [ADDR_W-1:0] inj_addr,
    input  logic [WIDTH-1:0]  inj_mask,
    input  logic              scrub_start,
    output logic              scrub_busy,
    output logic              scrub_done,
    output logic [CNT_W-1:0]  corr_cnt
);

    localparam int LO    = (AFROM < ATO) ? AFROM : ATO;
    localparam int HI    = (AFROM < ATO) ? ATO : AFROM;
    localparam int N     = HI - LO + 1;
    localparam int IW    = (N > 1) ? $clog2(N) : 1;
    localparam int DEPTH = 1 << IW;
    localparam bit ASC   = (AFROM <= ATO);

    // Storage is addressed by offset from the low bound; ptr walks these offsets.
    localparam logic [IW-1:0] P_FIRST = IW'(AFROM - LO);
    localparam logic [IW-1:0] P_LAST  = IW'(ATO - LO);

    logic [WIDTH-1:0] mem [COPIES][DEPTH];
    logic [WIDTH-1:0] cp  [COPIES];

    logic          wr_ok, rd_ok, inj_ok;
    logic [IW-1:0] wr_idx, rd_idx, inj_idx;

    scrub_state_t  state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic          load_en, check_en, wb_en, user_hit;

    logic [WIDTH-1:0] rd_vote, sc_vote;
    logic             rd_mis, sc_mis;

    function automatic logic [IW-1:0] to_idx(input logic [ADDR_W-1:0] a);
        return IW'(int'(a) - LO);
    endfunction

    assign wr_ok   = idx_valid(int'(wr_addr), AFROM, ATO);
    assign rd_ok   = idx_valid(int'(rd_addr), AFROM, ATO);
    assign inj_ok  = inj_en && idx_valid(int'(inj_addr), AFROM, ATO);
    assign wr_idx  = to_idx(wr_addr);
    assign rd_idx  = to_idx(rd_addr);
    assign inj_idx = to_idx(inj_addr);

    tmr_majority_voter #(.WIDTH(WIDTH)) u_rd_vote (
        .a        (mem[0][rd_idx]),
        .b        (mem[1][rd_idx]),
        .c        (mem[2][rd_idx]),
        .voted    (rd_vote),
        .mismatch (rd_mis)
    );

    tmr_majority_voter #(.WIDTH(WIDTH)) u_sc_vote (
        .a        (cp[0]),
        .b        (cp[1]),
        .c        (cp[2]),
        .voted    (sc_vote),
        .mismatch (sc_mis)
    );

    // A user write to the entry under CHECK wins; that entry is left as the user wrote it.
    assign user_hit = wr_en && wr_ok && (wr_idx == ptr);
    assign wb_en    = check_en && sc_mis && !user_hit;

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        scrub_busy = 1'b0;
        scrub_done = 1'b0;
        load_en    = 1'b0;
        check_en   = 1'b0;
        case (state)
            IDLE: begin
                if (scrub_start) begin
                    state_nxt = LOAD;
                    ptr_nxt   = P_FIRST;
                end
            end
            LOAD: begin
                scrub_busy = 1'b1;
                load_en    = 1'b1;
                state_nxt  = CHECK;
            end
            CHECK: begin
                scrub_busy = 1'b1;
                check_en   = 1'b1;
                if (ptr == P_LAST) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = LOAD;
                    ptr_nxt   = ASC ? ptr + 1'b1 : ptr - 1'b1;
                end
            end
            DONE: begin
                scrub_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= P_FIRST;
            corr_cnt <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            rd_valid <= rd_en;
            if (wb_en && (corr_cnt != {CNT_W{1'b1}})) begin
                corr_cnt <= corr_cnt + 1'b1;
            end
            if (rd_en) begin
                rd_data <= rd_ok ? rd_vote : '0;
                rd_err  <= rd_ok && rd_mis;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_en) begin
            for (int c = 0; c < COPIES; c++) begin
                cp[c] <= mem[c][ptr];
            end
        end
    end

    // Later assignments override earlier ones: injection < scrub write-back < user write.
    always_ff @(posedge clk) begin
        for (int c = 0; c < COPIES; c++) begin
            if (inj_ok && (inj_copy == 2'(c))) begin
                mem[c][inj_idx] <= mem[c][inj_idx] ^ inj_mask;
            end
            if (wb_en) begin
                mem[c][ptr] <= sc_vote;
            end
            if (wr_en && wr_ok) begin
                mem[c][wr_idx] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_tmr_array_scrubber.sv
// Bench for tmr_array_scrubber: four instances covering ascending, descending,
// narrow-counter and single-entry ranges, with a read scoreboard and scrub timing checks.
module tb_tmr_array_scrubber;

    localparam int NI = 4;
    localparam int AF [NI] = '{0, 7, 0, 7};
    localparam int AT [NI] = '{7, 0, 7, 7};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rst, wr_en, rd_en, inj_en, scrub_start;
    logic [NI-1:0] rd_valid, rd_err, scrub_busy, scrub_done;
    logic [3:0]    wr_addr [NI];
    logic [3:0]    rd_addr [NI];
    logic [3:0]    inj_addr [NI];
    logic [7:0]    wr_data [NI];
    logic [7:0]    inj_mask [NI];
    logic [1:0]    inj_copy [NI];
    logic [7:0]    rd_data [NI];
    logic [7:0]    corr_cnt [NI];

    genvar g;
    for (g = 0; g < NI; g++) begin : g_dut
        localparam int CW = (g == 2) ? 2 : 8;
        logic [CW-1:0] cnt_w;
        assign corr_cnt[g] = 8'(cnt_w);
        tmr_array_scrubber #(
            .WIDTH(8), .AFROM(AF[g]), .ATO(AT[g]), .ADDR_W(4), .CNT_W(CW)
        ) u_dut (
            .clk         (clk),
            .rst         (rst[g]),
            .wr_en       (wr_en[g]),
            .wr_addr     (wr_addr[g]),
            .wr_data     (wr_data[g]),
            .rd_en       (rd_en[g]),
            .rd_addr     (rd_addr[g]),
            .rd_data     (rd_data[g]),
            .rd_valid    (rd_valid[g]),
            .rd_err      (rd_err[g]),
            .inj_en      (inj_en[g]),
            .inj_copy    (inj_copy[g]),
            .inj_addr    (inj_addr[g]),
            .inj_mask    (inj_mask[g]),
            .scrub_start (scrub_start[g]),
            .scrub_busy  (scrub_busy[g]),
            .scrub_done  (scrub_done[g]),
            .corr_cnt    (cnt_w)
        );
    end

    typedef struct {
        logic       wr;
        logic       rd;
        logic       inj;
        logic [3:0] addr;
        logic [7:0] data;
        logic [1:0] copy;
        logic [7:0] mask;
        logic [7:0] exp_d;
        logic       exp_e;
    } vec_t;

    typedef struct {
        int         inst;
        logic [3:0] addr;
        logic [7:0] d;
        logic       e;
    } exp_t;

    exp_t sb [$];
    vec_t tab1 [$];
    vec_t tab2 [$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    function automatic vec_t mk(input logic w, input logic r, input logic i, input logic [3:0] a,
                                input logic [7:0] d, input logic [1:0] c, input logic [7:0] m,
                                input logic [7:0] ed, input logic ee);
        vec_t v;
        v.wr = w; v.rd = r; v.inj = i; v.addr = a; v.data = d;
        v.copy = c; v.mask = m; v.exp_d = ed; v.exp_e = ee;
        return v;
    endfunction

    function automatic vec_t W(input logic [3:0] a, input logic [7:0] d);
        return mk(1'b1, 1'b0, 1'b0, a, d, 2'd0, 8'h00, 8'h00, 1'b0);
    endfunction
    function automatic vec_t R(input logic [3:0] a, input logic [7:0] ed, input logic ee);
        return mk(1'b0, 1'b1, 1'b0, a, 8'h00, 2'd0, 8'h00, ed, ee);
    endfunction
    function automatic vec_t I(input logic [1:0] c, input logic [3:0] a, input logic [7:0] m);
        return mk(1'b0, 1'b0, 1'b1, a, 8'h00, c, m, 8'h00, 1'b0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int k, input vec_t v);
        exp_t e;
        if (v.rd) begin
            e.inst = k; e.addr = v.addr; e.d = v.exp_d; e.e = v.exp_e;
            sb.push_back(e);
        end
        wr_en[k] = v.wr; rd_en[k] = v.rd; inj_en[k] = v.inj;
        wr_addr[k] = v.addr; rd_addr[k] = v.addr; inj_addr[k] = v.addr;
        wr_data[k] = v.data; inj_copy[k] = v.copy; inj_mask[k] = v.mask;
        tick();
        wr_en[k] = 1'b0; rd_en[k] = 1'b0; inj_en[k] = 1'b0;
    endtask

    // Counts cycles from the start strobe to scrub_done; optionally drives one user write at coll_cyc.
    task automatic run_scrub(input int k, input int exp_cyc, input int coll_cyc,
                             input logic [3:0] ca, input logic [7:0] cd, input string tag);
        int c = 0;
        bit seen = 1'b0;
        scrub_start[k] = 1'b1;
        while (!seen && c < 200) begin
            tick();
            c++;
            scrub_start[k] = 1'b0;
            wr_en[k] = 1'b0;
            if (c == 1) check({tag, "_busy_start"}, 32'(scrub_busy[k]), 32'd1);
            if (c == coll_cyc) begin
                wr_en[k] = 1'b1; wr_addr[k] = ca; wr_data[k] = cd;
            end
            if (scrub_done[k]) seen = 1'b1;
        end
        check({tag, "_done_cycles"}, 32'(c), 32'(exp_cyc));
        check({tag, "_busy_at_done"}, 32'(scrub_busy[k]), 32'd0);
        tick();
        check({tag, "_done_pulse_len"}, 32'(scrub_done[k]), 32'd0);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rd_valid[k]) begin
                check($sformatf("sb_expect_i%0d", k), 32'(sb.size() != 0 && sb[0].inst == k), 32'd1);
                if (sb.size() != 0 && sb[0].inst == k) begin
                    check($sformatf("rd_data_i%0d_a%0d", k, sb[0].addr), 32'(rd_data[k]), 32'(sb[0].d));
                    check($sformatf("rd_err_i%0d_a%0d", k, sb[0].addr), 32'(rd_err[k]), 32'(sb[0].e));
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        int ndone;
        rst = '1; wr_en = '0; rd_en = '0; inj_en = '0; scrub_start = '0;
        for (int k = 0; k < NI; k++) begin
            wr_addr[k] = '0; rd_addr[k] = '0; inj_addr[k] = '0;
            wr_data[k] = '0; inj_mask[k] = '0; inj_copy[k] = '0;
        end
        repeat (3) tick();
        rst = '0;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_rd_valid_i%0d", k), 32'(rd_valid[k]), 32'd0);
            check($sformatf("rst_rd_data_i%0d", k), 32'(rd_data[k]), 32'd0);
            check($sformatf("rst_busy_i%0d", k), 32'(scrub_busy[k]), 32'd0);
            check($sformatf("rst_cnt_i%0d", k), 32'(corr_cnt[k]), 32'd0);
        end

        // Every valid entry gets a known value so copies start out identical.
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 8; a++) apply(k, W(4'(a), 8'(8'h10 + a)));
        apply(3, W(4'd7, 8'h42));

        tab1.push_back(W(4'd3, 8'hA5));
        tab1.push_back(R(4'd3, 8'hA5, 1'b0));
        tab1.push_back(I(2'd1, 4'd3, 8'h0F));
        tab1.push_back(R(4'd3, 8'hA5, 1'b1));
        tab1.push_back(R(4'd9, 8'h00, 1'b0));
        tab1.push_back(W(4'd9, 8'hFF));
        tab1.push_back(R(4'd1, 8'h11, 1'b0));
        tab1.push_back(I(2'd3, 4'd2, 8'hFF));
        tab1.push_back(R(4'd2, 8'h12, 1'b0));
        tab1.push_back(I(2'd0, 4'd9, 8'hFF));
        tab1.push_back(R(4'd1, 8'h11, 1'b0));

        tab2.push_back(I(2'd0, 4'd4, 8'h01));
        tab2.push_back(I(2'd2, 4'd4, 8'h80));
        tab2.push_back(R(4'd4, 8'h14, 1'b1));
        tab2.push_back(I(2'd0, 4'd6, 8'h01));
        tab2.push_back(I(2'd1, 4'd6, 8'h01));
        tab2.push_back(R(4'd6, 8'h17, 1'b1));
        tab2.push_back(mk(1'b1, 1'b1, 1'b0, 4'd1, 8'h77, 2'd0, 8'h00, 8'h11, 1'b0));
        tab2.push_back(R(4'd1, 8'h77, 1'b0));
        tab2.push_back(mk(1'b1, 1'b0, 1'b1, 4'd5, 8'h55, 2'd0, 8'hFF, 8'h00, 1'b0));
        tab2.push_back(R(4'd5, 8'h55, 1'b0));
        tab2.push_back(I(2'd2, 4'd5, 8'hF0));
        tab2.push_back(R(4'd5, 8'h55, 1'b1));

        // Ascending range: single correction.
        foreach (tab1[i]) apply(0, tab1[i]);
        run_scrub(0, 17, 0, 4'd0, 8'h00, "asc");
        check("asc_cnt", 32'(corr_cnt[0]), 32'd1);
        apply(0, R(4'd3, 8'hA5, 1'b0));

        // Collision: user write lands in the cycle CHECK targets index 5.
        foreach (tab2[i]) apply(0, tab2[i]);
        run_scrub(0, 17, 12, 4'd5, 8'h3C, "coll");
        check("coll_cnt", 32'(corr_cnt[0]), 32'd3);
        apply(0, R(4'd5, 8'h3C, 1'b0));
        apply(0, R(4'd4, 8'h14, 1'b0));
        apply(0, R(4'd6, 8'h17, 1'b0));

        // Reset in the LOAD cycle of index 2.
        apply(0, I(2'd0, 4'd0, 8'h02));
        apply(0, I(2'd1, 4'd7, 8'h01));
        scrub_start[0] = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            scrub_start[0] = 1'b0;
        end
        check("rstmid_busy_before", 32'(scrub_busy[0]), 32'd1);
        check("rstmid_cnt_before", 32'(corr_cnt[0]), 32'd4);
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        check("rstmid_busy", 32'(scrub_busy[0]), 32'd0);
        check("rstmid_cnt", 32'(corr_cnt[0]), 32'd0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            if (scrub_done[0]) ndone++;
            tick();
        end
        check("rstmid_no_done", 32'(ndone), 32'd0);
        apply(0, R(4'd7, 8'h17, 1'b1));
        apply(0, R(4'd0, 8'h10, 1'b0));

        // Descending range; the collision at cycle 4 proves index 6 is the second entry visited.
        apply(1, I(2'd0, 4'd7, 8'h01));
        apply(1, I(2'd2, 4'd0, 8'h80));
        apply(1, I(2'd1, 4'd6, 8'hFF));
        apply(1, R(4'd7, 8'h17, 1'b1));
        apply(1, R(4'd0, 8'h10, 1'b1));
        apply(1, R(4'd6, 8'h16, 1'b1));
        run_scrub(1, 17, 4, 4'd6, 8'h66, "desc");
        check("desc_cnt", 32'(corr_cnt[1]), 32'd2);
        apply(1, R(4'd7, 8'h17, 1'b0));
        apply(1, R(4'd0, 8'h10, 1'b0));
        apply(1, R(4'd6, 8'h66, 1'b0));

        // Two-bit counter saturates at 3 after four corrections.
        for (int a = 0; a < 8; a += 2) apply(2, I(2'd0, 4'(a), 8'h01));
        run_scrub(2, 17, 0, 4'd0, 8'h00, "sat");
        check("sat_cnt", 32'(corr_cnt[2]), 32'd3);
        apply(2, R(4'd6, 8'h16, 1'b0));

        // Single-entry range at index 7.
        apply(3, I(2'd1, 4'd7, 8'h42));
        apply(3, R(4'd7, 8'h42, 1'b1));
        apply(3, R(4'd0, 8'h00, 1'b0));
        apply(3, R(4'd9, 8'h00, 1'b0));
        run_scrub(3, 3, 0, 4'd0, 8'h00, "one");
        check("one_cnt", 32'(corr_cnt[3]), 32'd1);
        apply(3, R(4'd7, 8'h42, 1'b0));

        repeat (3) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
